// File: rtl/rca_nibble_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package rca_nibble_seq_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_nibble_seq_adder_slice.sv
// Combinational 4-bit ripple carry slice, time-shared by the nibble-serial adder.
module ripple_carry_4_bit
  import rca_nibble_seq_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  always_comb begin : ripple
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_nibble_seq_adder.sv
// WIDTH-bit adder that feeds one nibble per cycle through a shared ripple slice,
// returning sum/cout over a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for operands
// ST_RUN  | one nibble per cycle through the slice, carry registered
// ST_DONE | out_valid=1, result held until out_ready
module rca_nibble_seq_adder
  import rca_nibble_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  ripple_carry_4_bit u_slice (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_sh_d = {slice_sum, sum_sh_q[WIDTH-1:NIBBLE_W]};
        carry_d  = slice_cout;
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with it.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    sum_d       = (state_d == ST_DONE) ? sum_sh_d : sum_q;
    cout_d      = (state_d == ST_DONE) ? carry_d : cout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_rca_nibble_seq_adder.sv
// Directed bench for the 16-bit nibble-serial adder.
module tb_rca_nibble_seq_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int errors = 0;
  int checks = 0;

  rca_nibble_seq_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, then presents operands for exactly one accepting edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic c,
                      output logic timeout);
    int n = 0;
    timeout = 1'b0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) timeout = 1'b1;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic timeout);
    lat = 0;
    timeout = 1'b0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%h cout=%b, want 1 0 0 0000 0",
               in_ready, out_valid, busy, sum, cout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic to_s, to_w;
    send(16'h1234, 16'h4321, 1'b0, to_s);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_run_flags: got busy=%b rdy=%b, want 1 0", busy, in_ready);
    end
    wait_result(lat, to_w);
    checks++;
    if (to_s || to_w || lat !== 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d (timeout=%b), want 4", lat, to_s | to_w);
    end
    checks++;
    if (sum !== 16'h5555 || cout !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_result: got sum=%h cout=%b rdy=%b busy=%b, want 5555 0 0 1",
               sum, cout, in_ready, busy);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_carry_chain();
    logic [15:0] va [4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000};
    logic [15:0] vb [4] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h8000};
    logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] es [4] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0000};
    logic        ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      int lat;
      logic to_s, to_w;
      send(va[i], vb[i], vc[i], to_s);
      wait_result(lat, to_w);
      checks++;
      if (to_s || to_w || sum !== es[i] || cout !== ec[i]) begin
        errors++;
        $display("FAIL carry_vec%0d: got sum=%h cout=%b (timeout=%b), want %h %b",
                 i, sum, cout, to_s | to_w, es[i], ec[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic to_s, to_w;
    out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 1'b1, to_s);
    wait_result(lat, to_w);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (to_s || to_w || out_valid !== 1'b1 || sum !== 16'h1011 || cout !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got vld=%b sum=%h cout=%b rdy=%b, want 1 1011 0 0",
                 i, out_valid, sum, cout, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_during_run();
    int lat;
    logic to_s, to_w;
    logic seen;
    send(16'h1234, 16'h4321, 1'b0, to_s);
    tick();
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'hAAAA;
    cin = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(lat, to_w);
    checks++;
    if (to_s || to_w || sum !== 16'h5555 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_run: got sum=%h cout=%b (timeout=%b), want 5555 0", sum, cout, to_s | to_w);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_queue: got extra out_valid=%b, want 0", seen);
    end
  endtask

  task automatic test_early_out_ready();
    int lat;
    logic to_s, to_w;
    out_ready = 1'b1;
    send(16'h00FF, 16'h0F01, 1'b0, to_s);
    wait_result(lat, to_w);
    checks++;
    if (to_s || to_w || lat !== 4 || sum !== 16'h1000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL early_ready_result: got lat=%0d sum=%h cout=%b, want 4 1000 0", lat, sum, cout);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_ready_one_cycle: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int acc = -1;
    logic xfer;
    logic [15:0] first_sum = 16'hDEAD;
    int lat;
    logic to_w;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    cin = 1'b0;
    tick();
    a = 16'h7FFF;
    b = 16'h0001;
    while (cyc < 20 && acc < 0) begin
      xfer = in_ready & in_valid;
      tick();
      cyc++;
      if (out_valid) first_sum = sum;
      if (xfer) begin
        acc = cyc;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc !== 6 || first_sum !== 16'h3333) begin
      errors++;
      $display("FAIL back_to_back_first: got accept_gap=%0d sum=%h, want 6 3333", acc, first_sum);
    end
    wait_result(lat, to_w);
    checks++;
    if (to_w || sum !== 16'h8000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_second: got sum=%h cout=%b, want 8000 0", sum, cout);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic to_s, to_w;
    logic seen;
    send(16'h1234, 16'h4321, 1'b0, to_s);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_run: got vld=%b busy=%b rdy=%b sum=%h, want 0 0 1 0000",
               out_valid, busy, in_ready, sum);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: got stray activity=%b, want 0", seen);
    end
    send(16'h0008, 16'h0008, 1'b0, to_s);
    wait_result(lat, to_w);
    checks++;
    if (to_s || to_w || sum !== 16'h0010 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: got sum=%h cout=%b, want 0010 0", sum, cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_ignore_during_run();
    test_early_out_ready();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
